// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one fixed-latency memory port between instruction fetch (IF) and load/store (LS).
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise LS has fixed priority on ties.
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_rdata,

    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [31:0] ls_addr,
    input  logic        ls_wen,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_wmask,
    output logic        ls_resp_valid,
    output logic [31:0] ls_rdata,

    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    // lat_cnt is 3 bits, so MEM_LAT must stay within 1..7.
    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } port_t;

    state_t     state;
    state_t     state_nxt;
    port_t      owner;
    port_t      owner_nxt;
    port_t      last_grant;
    port_t      last_grant_nxt;
    logic [2:0] lat_cnt;
    logic [2:0] lat_cnt_nxt;
    logic       owner_wen;

    logic       grant_if;
    logic       grant_ls;
    logic       resp_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            lat_cnt    <= 3'd0;
            last_grant <= OWN_LS;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            lat_cnt    <= lat_cnt_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Remembers whether the in-flight LS access was a write so its ack returns zero data.
    always_ff @(posedge clock) begin
        if (grant_ls) begin
            owner_wen <= ls_wen;
        end else if (grant_if) begin
            owner_wen <= 1'b0;
        end
    end

    // Grant is only possible in IDLE and never while reset is asserted.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state == IDLE && !reset) begin
            if (if_req_valid && ls_req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
                grant_if = (last_grant == OWN_LS);
`else
                grant_if = 1'b0;
`endif
                grant_ls = !grant_if;
            end else begin
                grant_if = if_req_valid;
                grant_ls = ls_req_valid;
            end
        end
    end

    assign resp_done = (state == WAIT) && (lat_cnt == LAT_LAST) && !reset;

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        lat_cnt_nxt    = lat_cnt;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (grant_if || grant_ls) begin
                    state_nxt      = WAIT;
                    owner_nxt      = grant_ls ? OWN_LS : OWN_IF;
                    last_grant_nxt = grant_ls ? OWN_LS : OWN_IF;
                    lat_cnt_nxt    = 3'd1;
                end
            end
            WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    lat_cnt_nxt = lat_cnt + 3'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign if_req_ready = grant_if;
    assign ls_req_ready = grant_ls;

    // IF accesses are always reads; write fields are only forwarded for LS writes.
    always_comb begin
        mem_valid = grant_if || grant_ls;
        mem_addr  = 32'd0;
        mem_wen   = 1'b0;
        mem_wdata = 32'd0;
        mem_wmask = 4'd0;
        if (grant_ls) begin
            mem_addr = ls_addr;
            if (ls_wen) begin
                mem_wen   = 1'b1;
                mem_wdata = ls_wdata;
                mem_wmask = ls_wmask;
            end
        end else if (grant_if) begin
            mem_addr = if_addr;
        end
    end

    always_comb begin
        if_resp_valid = 1'b0;
        if_rdata      = 32'd0;
        ls_resp_valid = 1'b0;
        ls_rdata      = 32'd0;
        if (resp_done) begin
            if (owner == OWN_IF) begin
                if_resp_valid = 1'b1;
                if_rdata      = mem_rdata;
            end else begin
                ls_resp_valid = 1'b1;
                ls_rdata      = owner_wen ? 32'd0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with MEM_LAT=2; expectations follow ARB_ROUND_ROBIN_EN when defined.
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clock;
    logic        reset;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_addr;
    logic        if_resp_valid;
    logic [31:0] if_rdata;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [31:0] ls_addr;
    logic        ls_wen;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wmask;
    logic        ls_resp_valid;
    logic [31:0] ls_rdata;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.MEM_LAT(LAT)) u_dut (
        .clock         (clock),
        .reset         (reset),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_resp_valid (if_resp_valid),
        .if_rdata      (if_rdata),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_addr       (ls_addr),
        .ls_wen        (ls_wen),
        .ls_wdata      (ls_wdata),
        .ls_wmask      (ls_wmask),
        .ls_resp_valid (ls_resp_valid),
        .ls_rdata      (ls_rdata),
        .mem_valid     (mem_valid),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rdata     (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        if_addr      = 32'h0000_1000;
        ls_addr      = 32'h0000_2000;
        tick();
        #1;
        n_checks++; if (if_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_if_ready got=%b exp=0", if_req_ready); end
        n_checks++; if (ls_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ls_ready got=%b exp=0", ls_req_ready); end
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_valid got=%b exp=0", mem_valid); end
        n_checks++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        n_checks++; if ({if_resp_valid, ls_resp_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_resp got=%b exp=00", {if_resp_valid, ls_resp_valid}); end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_if_read();
        if_req_valid = 1'b1;
        if_addr      = 32'h8000_0000;
        ls_wdata     = 32'hCAFE_F00D;
        ls_wmask     = 4'hF;
        ls_wen       = 1'b1;
        #1;
        n_checks++; if (if_req_ready !== 1'b1) begin n_fail++; $display("FAIL if_ready got=%b exp=1", if_req_ready); end
        n_checks++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL if_mem_valid got=%b exp=1", mem_valid); end
        n_checks++; if (mem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL if_mem_addr got=%h exp=80000000", mem_addr); end
        n_checks++; if ({mem_wen, mem_wmask, mem_wdata} !== 37'd0) begin n_fail++; $display("FAIL if_mem_write got=%b/%h/%h exp=0/0/0", mem_wen, mem_wmask, mem_wdata); end
        tick();
        if_req_valid = 1'b0;
        mem_rdata    = 32'h0000_0413;
        #1;
        n_checks++; if (if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL if_early_resp got=%b exp=0", if_resp_valid); end
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL if_wait_mem_valid got=%b exp=0", mem_valid); end
        tick();
        #1;
        n_checks++; if (if_resp_valid !== 1'b1) begin n_fail++; $display("FAIL if_resp got=%b exp=1", if_resp_valid); end
        n_checks++; if (if_rdata !== 32'h0000_0413) begin n_fail++; $display("FAIL if_rdata got=%h exp=00000413", if_rdata); end
        n_checks++; if (ls_resp_valid !== 1'b0) begin n_fail++; $display("FAIL if_ls_resp got=%b exp=0", ls_resp_valid); end
        tick();
        #1;
        n_checks++; if (if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL if_resp_pulse got=%b exp=0", if_resp_valid); end
    endtask

    task automatic test_ls_write();
        ls_req_valid = 1'b1;
        ls_addr      = 32'h8000_1000;
        ls_wen       = 1'b1;
        ls_wdata     = 32'hDEAD_BEEF;
        ls_wmask     = 4'hF;
        #1;
        n_checks++; if (ls_req_ready !== 1'b1) begin n_fail++; $display("FAIL lsw_ready got=%b exp=1", ls_req_ready); end
        n_checks++; if (mem_addr !== 32'h8000_1000) begin n_fail++; $display("FAIL lsw_addr got=%h exp=80001000", mem_addr); end
        n_checks++; if (mem_wen !== 1'b1) begin n_fail++; $display("FAIL lsw_wen got=%b exp=1", mem_wen); end
        n_checks++; if (mem_wmask !== 4'hF) begin n_fail++; $display("FAIL lsw_wmask got=%h exp=f", mem_wmask); end
        n_checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lsw_wdata got=%h exp=deadbeef", mem_wdata); end
        tick();
        ls_req_valid = 1'b0;
        ls_wen       = 1'b0;
        tick();
        mem_rdata = 32'h1234_5678;
        #1;
        n_checks++; if (ls_resp_valid !== 1'b1) begin n_fail++; $display("FAIL lsw_resp got=%b exp=1", ls_resp_valid); end
        n_checks++; if (ls_rdata !== 32'd0) begin n_fail++; $display("FAIL lsw_rdata got=%h exp=0", ls_rdata); end
        n_checks++; if (if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL lsw_if_resp got=%b exp=0", if_resp_valid); end
        tick();
    endtask

    task automatic test_ls_read();
        ls_req_valid = 1'b1;
        ls_addr      = 32'h8000_2004;
        ls_wen       = 1'b0;
        ls_wmask     = 4'hC;
        ls_wdata     = 32'h5555_AAAA;
        #1;
        n_checks++; if (ls_req_ready !== 1'b1) begin n_fail++; $display("FAIL lsr_ready got=%b exp=1", ls_req_ready); end
        n_checks++; if ({mem_wen, mem_wmask} !== 5'd0) begin n_fail++; $display("FAIL lsr_mask got=%b/%h exp=0/0", mem_wen, mem_wmask); end
        tick();
        ls_req_valid = 1'b0;
        tick();
        mem_rdata = 32'hA5A5_0F0F;
        #1;
        n_checks++; if (ls_resp_valid !== 1'b1) begin n_fail++; $display("FAIL lsr_resp got=%b exp=1", ls_resp_valid); end
        n_checks++; if (ls_rdata !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL lsr_rdata got=%h exp=a5a50f0f", ls_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_if;
        logic exp_ls;
        do_reset();
        if_addr      = 32'h8000_0100;
        ls_addr      = 32'h8000_3000;
        ls_wen       = 1'b0;
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            exp_if = 1'b0;
            exp_ls = 1'b0;
            if (c % 3 == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
                exp_if = ((c / 3) % 2 == 0);
                exp_ls = ((c / 3) % 2 == 1);
`else
                exp_ls = 1'b1;
`endif
            end
            #1;
            n_checks++; if (if_req_ready !== exp_if) begin n_fail++; $display("FAIL b2b_if_ready c=%0d got=%b exp=%b", c, if_req_ready, exp_if); end
            n_checks++; if (ls_req_ready !== exp_ls) begin n_fail++; $display("FAIL b2b_ls_ready c=%0d got=%b exp=%b", c, ls_req_ready, exp_ls); end
            tick();
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_wait();
        if_req_valid = 1'b1;
        if_addr      = 32'h8000_0040;
        #1;
        n_checks++; if (if_req_ready !== 1'b1) begin n_fail++; $display("FAIL rw_accept got=%b exp=1", if_req_ready); end
        tick();
        if_req_valid = 1'b0;
        reset        = 1'b1;
        #1;
        n_checks++; if (if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rw_resp_in_reset got=%b exp=0", if_resp_valid); end
        tick();
        reset        = 1'b0;
        ls_req_valid = 1'b1;
        ls_addr      = 32'h8000_0080;
        ls_wen       = 1'b0;
        mem_rdata    = 32'h0BAD_0BAD;
        #1;
        n_checks++; if (if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rw_discard got=%b exp=0", if_resp_valid); end
        n_checks++; if (ls_req_ready !== 1'b1) begin n_fail++; $display("FAIL rw_new_accept got=%b exp=1", ls_req_ready); end
        tick();
        ls_req_valid = 1'b0;
        tick();
        mem_rdata = 32'h0000_BEEF;
        #1;
        n_checks++; if ({ls_resp_valid, ls_rdata} !== {1'b1, 32'h0000_BEEF}) begin n_fail++; $display("FAIL rw_ls_resp got=%b/%h exp=1/0000beef", ls_resp_valid, ls_rdata); end
        tick();
    endtask

    task automatic test_request_during_wait();
        ls_req_valid = 1'b1;
        ls_addr      = 32'h8000_0200;
        ls_wen       = 1'b0;
        #1;
        n_checks++; if (ls_req_ready !== 1'b1) begin n_fail++; $display("FAIL rdw_ls_accept got=%b exp=1", ls_req_ready); end
        tick();
        ls_req_valid = 1'b0;
        if_req_valid = 1'b1;
        if_addr      = 32'h8000_0300;
        #1;
        n_checks++; if (if_req_ready !== 1'b0) begin n_fail++; $display("FAIL rdw_if_wait1 got=%b exp=0", if_req_ready); end
        tick();
        #1;
        n_checks++; if (ls_resp_valid !== 1'b1) begin n_fail++; $display("FAIL rdw_ls_resp got=%b exp=1", ls_resp_valid); end
        n_checks++; if (if_req_ready !== 1'b0) begin n_fail++; $display("FAIL rdw_if_wait2 got=%b exp=0", if_req_ready); end
        tick();
        #1;
        n_checks++; if (if_req_ready !== 1'b1) begin n_fail++; $display("FAIL rdw_if_grant got=%b exp=1", if_req_ready); end
        n_checks++; if (mem_addr !== 32'h8000_0300) begin n_fail++; $display("FAIL rdw_if_addr got=%h exp=80000300", mem_addr); end
        tick();
        if_req_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset        = 1'b1;
        if_req_valid = 1'b0;
        if_addr      = 32'd0;
        ls_req_valid = 1'b0;
        ls_addr      = 32'd0;
        ls_wen       = 1'b0;
        ls_wdata     = 32'd0;
        ls_wmask     = 4'd0;
        mem_rdata    = 32'd0;
        tick();
        test_reset();
        test_if_read();
        test_ls_write();
        test_ls_read();
        test_back_to_back();
        test_reset_in_wait();
        test_request_during_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
